min_eu: RTL and testbench

- Execution unit of the Min microcoded processor.
- Holds PC, MAR, MDR, ACC, IR and the condition codes, plus an ALU, an internal 16-bit bus and a synchronous main memory.
- Driven each cycle by the 18-bit execution-control field of the registered control word and by the 3-bit ALU opcode from the instruction decoder.
- Returns the IR (to the decoder), the condition codes (to next-state logic) and a memory observation word.

---
 rtl/min_pkg.sv | 50 +++++
 rtl/min_alu.sv | 54 +++++
 rtl/min_eu.sv | 110 +++++++++++
 tb/tb_min_eu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared definitions for the Min processor: control-field bit positions,
// internal bus source codes, ALU opcodes and condition-code positions.
package min_pkg;

  localparam int EU_W = 18;

  // eucntl bit positions
  localparam int EU_PC_LD         = 17;
  localparam int EU_PC_INC        = 16;
  localparam int EU_IR_LD         = 15;
  localparam int EU_MAR_LD        = 14;
  localparam int EU_MDR_LD_MEM    = 13;
  localparam int EU_MDR_LD_BUS    = 12;
  localparam int EU_MEM_WR        = 11;
  localparam int EU_ACC_LD        = 10;
  localparam int EU_CC_LD         = 9;
  localparam int EU_BUS_SRC_HI    = 8;
  localparam int EU_BUS_SRC_LO    = 6;
  localparam int EU_ALU_FORCE_ADD = 5;
  localparam int EU_ALU_B_ONE     = 4;

  // condition-code bit positions in cc
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  typedef enum logic [2:0] {
    BUS_PC    = 3'b000,
    BUS_ACC   = 3'b001,
    BUS_MDR   = 3'b010,
    BUS_IR_ZX = 3'b011,
    BUS_ALU   = 3'b100,
    BUS_IR_SX = 3'b101,
    BUS_ZERO  = 3'b110,
    BUS_ONES  = 3'b111
  } bus_src_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_PASS = 3'b110,
    ALU_SHL  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/min_alu.sv
// Combinational ALU: result and {N,Z,C,V} from A, B and the operation.
module min_alu
  import min_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  alu_op_e       i_op,
  output logic [DW-1:0] o_res,
  output logic [3:0]    o_flags
);

  logic [DW:0]   w_sum;
  logic [DW-1:0] w_res;
  logic          w_c;
  logic          w_v;

  // Operation select; carry/overflow only meaningful for ADD, SUB and SHL
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (i_a[DW-1] == i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
      end
      ALU_SUB: begin
        w_sum = {1'b0, i_a} + {1'b0, ~i_b} + (DW+1)'(1);
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (i_a[DW-1] != i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
      end
      ALU_AND:  w_res = i_a & i_b;
      ALU_OR:   w_res = i_a | i_b;
      ALU_XOR:  w_res = i_a ^ i_b;
      ALU_NOT:  w_res = ~i_a;
      ALU_PASS: w_res = i_b;
      ALU_SHL: begin
        w_res = {i_a[DW-2:0], 1'b0};
        w_c   = i_a[DW-1];
      end
      default: w_res = '0;
    endcase
  end

  assign o_res   = w_res;
  assign o_flags = {w_res[DW-1], (w_res == '0), w_c, w_v};

endmodule

// File: rtl/min_eu.sv
// Min execution unit: PC, MAR, MDR, ACC, IR, cc, internal bus, ALU and
// synchronous main memory, all steered by the registered control field.
module min_eu
  import min_pkg::*;
#(
  parameter int    DW       = 16,
  parameter int    AW       = 8,
  parameter int    OBS_ADDR = 17,
  parameter string MEM_INIT = ""
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [EU_W-1:0] eucntl,
  input  logic [2:0]      opcntl,
  output logic [3:0]      cc,
  output logic [DW-1:0]   ifd,
  output logic [DW-1:0]   mem17
);

  localparam logic [AW-1:0] OBS_IDX = AW'(OBS_ADDR);

  logic [DW-1:0] r_pc;
  logic [AW-1:0] r_mar;
  logic [DW-1:0] r_mdr;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_ir;
  logic [3:0]    r_cc;
  logic [DW-1:0] r_mem [2**AW];

  logic [DW-1:0] w_bus;
  logic [DW-1:0] w_alu_b;
  logic [DW-1:0] w_alu_res;
  logic [3:0]    w_alu_flags;
  logic [DW-1:0] w_mem_rd;
  bus_src_e      w_bus_src;
  alu_op_e       w_alu_op;
  logic          w_unused;

  // Reserved low control bits carry no function
  assign w_unused  = ^eucntl[3:0];

  assign w_bus_src = bus_src_e'(eucntl[EU_BUS_SRC_HI:EU_BUS_SRC_LO]);
  assign w_alu_op  = eucntl[EU_ALU_FORCE_ADD] ? ALU_ADD : alu_op_e'(opcntl);
  assign w_alu_b   = eucntl[EU_ALU_B_ONE] ? DW'(1) : r_mdr;
  assign w_mem_rd  = r_mem[r_mar];

  min_alu #(.DW(DW)) u_alu (
    .i_a     (r_acc),
    .i_b     (w_alu_b),
    .i_op    (w_alu_op),
    .o_res   (w_alu_res),
    .o_flags (w_alu_flags)
  );

  // Internal bus source multiplexer
  always_comb begin
    w_bus = '0;
    case (w_bus_src)
      BUS_PC:    w_bus = r_pc;
      BUS_ACC:   w_bus = r_acc;
      BUS_MDR:   w_bus = r_mdr;
      BUS_IR_ZX: w_bus = {{(DW-8){1'b0}}, r_ir[7:0]};
      BUS_ALU:   w_bus = w_alu_res;
      BUS_IR_SX: w_bus = {{(DW-8){r_ir[7]}}, r_ir[7:0]};
      BUS_ZERO:  w_bus = '0;
      BUS_ONES:  w_bus = '1;
      default:   w_bus = '0;
    endcase
  end

  // Datapath registers: all loads sample pre-edge values in parallel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_acc <= '0;
      r_ir  <= '0;
      r_cc  <= '0;
    end else begin
      if (eucntl[EU_PC_LD])
        r_pc <= w_bus;
      else if (eucntl[EU_PC_INC])
        r_pc <= r_pc + DW'(1);
      if (eucntl[EU_IR_LD])
        r_ir <= w_mem_rd;
      if (eucntl[EU_MAR_LD])
        r_mar <= w_bus[AW-1:0];
      if (eucntl[EU_MDR_LD_MEM])
        r_mdr <= w_mem_rd;
      else if (eucntl[EU_MDR_LD_BUS])
        r_mdr <= w_bus;
      if (eucntl[EU_ACC_LD])
        r_acc <= w_bus;
      if (eucntl[EU_CC_LD])
        r_cc <= w_alu_flags;
    end
  end

  // Memory write; reads above see the old word in the same cycle
  always_ff @(posedge clock) begin
    if (eucntl[EU_MEM_WR] && !reset)
      r_mem[r_mar] <= r_mdr;
  end

  assign cc    = r_cc;
  assign ifd   = r_ir;
  assign mem17 = r_mem[OBS_IDX];

endmodule

// File: tb/tb_min_eu.sv
// Directed bench for min_eu: a register-level model of the execution unit is
// stepped with every control word and compared against ifd, cc and mem17 on
// each falling edge; literal checks pin the key results.
module tb_min_eu;

  // control-field masks built from the documented bit map
  localparam logic [17:0] PC_LD   = 18'h1 << 17;
  localparam logic [17:0] PC_INC  = 18'h1 << 16;
  localparam logic [17:0] IR_LD   = 18'h1 << 15;
  localparam logic [17:0] MAR_LD  = 18'h1 << 14;
  localparam logic [17:0] MDR_MEM = 18'h1 << 13;
  localparam logic [17:0] MDR_BUS = 18'h1 << 12;
  localparam logic [17:0] MEM_WR  = 18'h1 << 11;
  localparam logic [17:0] ACC_LD  = 18'h1 << 10;
  localparam logic [17:0] CC_LD   = 18'h1 << 9;
  localparam logic [17:0] F_ADD   = 18'h1 << 5;
  localparam logic [17:0] B_ONE   = 18'h1 << 4;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_OR = 3'd3, OP_XOR = 3'd4, OP_NOT = 3'd5,
                         OP_PASS = 3'd6, OP_SHL = 3'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] eucntl = '0;
  logic [2:0]  opcntl = '0;
  logic [3:0]  cc;
  logic [15:0] ifd;
  logic [15:0] mem17;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // model state
  logic [15:0] m_pc, m_mdr, m_acc, m_ir;
  logic [7:0]  m_mar;
  logic [3:0]  m_cc;
  logic [15:0] m_mem [256];
  bit          m_known [256];

  min_eu #(.DW(16), .AW(8), .OBS_ADDR(17), .MEM_INIT("")) dut (
    .clock  (clock),
    .reset  (reset),
    .eucntl (eucntl),
    .opcntl (opcntl),
    .cc     (cc),
    .ifd    (ifd),
    .mem17  (mem17)
  );

  // clock
  always #5 clock = ~clock;

  function automatic logic [17:0] bs(input int src);
    return 18'(src) << 6;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ALU from the arithmetic definitions: {flags, result}
  function automatic logic [19:0] m_alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int s;
    logic [15:0] r = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      OP_ADD: begin
        r = a + b; c = (ua + ub) > 65535;
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        r = a - b; c = (ua >= ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_PASS: r = b;
      default: begin r = a << 1; c = a[15]; end
    endcase
    return {r[15], (r == 16'h0), c, v, r};
  endfunction

  function automatic logic [15:0] m_bus(input logic [2:0] src, input logic [15:0] alu_r);
    case (src)
      3'd0: return m_pc;
      3'd1: return m_acc;
      3'd2: return m_mdr;
      3'd3: return {8'h00, m_ir[7:0]};
      3'd4: return alu_r;
      3'd5: return {{8{m_ir[7]}}, m_ir[7:0]};
      3'd6: return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic model_clear();
    m_pc = '0; m_mar = '0; m_mdr = '0; m_acc = '0; m_ir = '0; m_cc = '0;
  endtask

  // one rising edge of the machine, from pre-edge state
  task automatic model_edge(input logic [17:0] c, input logic [2:0] op);
    logic [19:0] a;
    logic [15:0] bus, rd, b;
    if (reset) return;
    b   = c[4] ? 16'h0001 : m_mdr;
    a   = m_alu(m_acc, b, c[5] ? OP_ADD : op);
    bus = m_bus(c[8:6], a[15:0]);
    rd  = m_mem[m_mar];
    if (c[11]) begin m_mem[m_mar] = m_mdr; m_known[m_mar] = 1'b1; end
    if (c[17]) m_pc = bus; else if (c[16]) m_pc = m_pc + 16'h1;
    if (c[15]) m_ir = rd;
    if (c[13]) m_mdr = rd; else if (c[12]) m_mdr = bus;
    if (c[14]) m_mar = bus[7:0];
    if (c[10]) m_acc = bus;
    if (c[9])  m_cc = a[19:16];
  endtask

  // driver: present a control word for one cycle
  task automatic step(input logic [17:0] c, input logic [2:0] op);
    eucntl = c;
    opcntl = op;
    @(posedge clock);
    model_edge(c, op);
    @(negedge clock);
    #1;
    eucntl = '0;
  endtask

  // build any ACC value by shift-and-increment through the ALU
  task automatic load_acc(input logic [15:0] v);
    step(ACC_LD | bs(6), OP_ADD);
    for (int i = 15; i >= 0; i--) begin
      step(ACC_LD | bs(4), OP_SHL);
      if (v[i]) step(ACC_LD | bs(4) | F_ADD | B_ONE, OP_SUB);
    end
  endtask

  task automatic load_mdr(input logic [15:0] v);
    load_acc(v);
    step(MDR_BUS | bs(1), OP_ADD);
  endtask

  // copy a bus source to mem[17] (MAR must be 17); clobbers MDR
  task automatic observe(input int src);
    step(MDR_BUS | bs(src), OP_ADD);
    step(MEM_WR, OP_ADD);
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("ifd", ifd, m_ir);
      chk("cc", {12'h0, cc}, {12'h0, m_cc});
      if (m_known[17]) chk("mem17", mem17, m_mem[17]);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
    model_clear();
    // power-on reset
    repeat (2) @(negedge clock);
    chk("rst_ifd", ifd, 16'h0000);
    chk("rst_cc", {12'h0, cc}, 16'h0000);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // fetch: mem[0] = A511, MAR <= PC, IR <= mem[MAR] with PC++
    load_mdr(16'hA511);
    step(MAR_LD | bs(6), OP_ADD);
    step(MEM_WR, OP_ADD);
    step(MAR_LD | bs(0), OP_ADD);
    step(IR_LD | PC_INC, OP_ADD);
    chk("fetch_ifd", ifd, 16'hA511);
    load_acc(16'd17);
    step(MAR_LD | bs(1), OP_ADD);
    observe(0);
    chk("fetch_pc", mem17, 16'h0001);

    // add with signed overflow
    load_mdr(16'h0001);
    load_acc(16'h7FFF);
    step(ACC_LD | CC_LD | bs(4), OP_ADD);
    chk("add_cc", {12'h0, cc}, 16'h0009);
    observe(1);
    chk("add_acc", mem17, 16'h8000);

    // subtract equal, then smaller minus larger
    load_mdr(16'd5);
    load_acc(16'd5);
    step(ACC_LD | CC_LD | bs(4), OP_SUB);
    chk("sub_eq_cc", {12'h0, cc}, 16'h0006);
    observe(1);
    chk("sub_eq_acc", mem17, 16'h0000);
    load_mdr(16'd5);
    load_acc(16'd3);
    step(ACC_LD | CC_LD | bs(4), OP_SUB);
    chk("sub_lt_cc", {12'h0, cc}, 16'h0008);
    observe(1);
    chk("sub_lt_acc", mem17, 16'hFFFE);

    // logic ops on ACC=F0F0, MDR=0FF0 (flags only)
    load_mdr(16'h0FF0);
    load_acc(16'hF0F0);
    step(CC_LD | bs(6), OP_AND);  chk("and_cc", {12'h0, cc}, 16'h0000);
    step(CC_LD | bs(6), OP_OR);   chk("or_cc",  {12'h0, cc}, 16'h0008);
    step(CC_LD | bs(6), OP_XOR);  chk("xor_cc", {12'h0, cc}, 16'h0008);
    step(CC_LD | bs(6), OP_NOT);  chk("not_cc", {12'h0, cc}, 16'h0000);
    step(CC_LD | bs(6), OP_PASS); chk("pass_cc", {12'h0, cc}, 16'h0000);
    step(ACC_LD | bs(4), OP_XOR);
    observe(1);
    chk("xor_acc", mem17, 16'hFF00);
    // 0 - 1 using the constant-one operand
    step(ACC_LD | bs(6), OP_ADD);
    step(ACC_LD | CC_LD | bs(4) | B_ONE, OP_SUB);
    chk("dec_cc", {12'h0, cc}, 16'h0008);

    // store / observe and read-before-write
    load_mdr(16'hBEEF);
    step(MEM_WR, OP_ADD);
    chk("store", mem17, 16'hBEEF);
    load_mdr(16'h1111);
    step(MEM_WR | MDR_MEM | MDR_BUS | bs(6), OP_ADD);
    chk("store_new", mem17, 16'h1111);
    step(MEM_WR, OP_ADD);
    chk("rbw_old", mem17, 16'hBEEF);

    // pc_ld beats pc_inc
    load_acc(16'h0040);
    step(PC_LD | PC_INC | bs(1), OP_ADD);
    observe(0);
    chk("pc_prio", mem17, 16'h0040);
    // PC wrap
    load_acc(16'hFFFF);
    step(PC_LD | bs(1), OP_ADD);
    step(PC_INC, OP_ADD);
    observe(0);
    chk("pc_wrap", mem17, 16'h0000);

    // sign and zero extension of IR[7:0]
    load_mdr(16'h0080);
    step(MEM_WR, OP_ADD);
    step(IR_LD, OP_ADD);
    chk("ir_80", ifd, 16'h0080);
    step(ACC_LD | bs(5), OP_ADD);
    observe(1);
    chk("sext", mem17, 16'hFF80);
    step(ACC_LD | bs(3), OP_ADD);
    observe(1);
    chk("zext", mem17, 16'h0080);

    // shift left
    load_acc(16'h8001);
    step(ACC_LD | CC_LD | bs(4), OP_SHL);
    chk("shl_cc", {12'h0, cc}, 16'h0002);
    observe(1);
    chk("shl_acc", mem17, 16'h0002);
    observe(7);
    chk("ones", mem17, 16'hFFFF);
    repeat (3) step(18'h0000F, OP_SUB);

    // mid-run reset with ACC=1234, PC=5
    load_acc(16'd5);
    step(PC_LD | bs(1), OP_ADD);
    load_acc(16'h1234);
    observe(1);
    chk("pre_rst", mem17, 16'h1234);
    step(CC_LD | bs(6), OP_NOT);
    reset = 1'b1;
    model_clear();
    #2;
    chk("arst_ifd", ifd, 16'h0000);
    chk("arst_cc", {12'h0, cc}, 16'h0000);
    chk("arst_mem17", mem17, 16'h1234);
    eucntl = MEM_WR | ACC_LD | PC_LD | bs(7);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset  = 1'b0;
    eucntl = '0;
    chk("rst_wr_sup", mem17, 16'h1234);
    step(CC_LD, OP_OR);
    chk("rst_acc_mdr", {12'h0, cc}, 16'h0004);
    step(MDR_BUS | bs(0), OP_ADD);
    step(CC_LD, OP_PASS);
    chk("rst_pc", {12'h0, cc}, 16'h0004);
    step(IR_LD, OP_ADD);
    chk("rst_mar", ifd, 16'hA511);

    @(negedge clock);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
